oled_spi_arbiter: RTL and testbench

- Shares the single SPI byte master (clk/sck/mosi/cs/dc engine) among NUM_REQ byte producers: OLED init sequencer, frame drawer, and a command/contrast path.
- Grants one requester at a time with round-robin priority and forwards that requester's byte and D/C flag to the master.
- Waits for the master's send-done, then returns a done pulse to the owner.
- Gates all but requester 0 until init_done, so no draw traffic reaches the panel before initialisation.

---
 rtl/oled_spi_arbiter_if.sv | 31 +++
 rtl/oled_spi_arbiter.sv | 135 +++++++++++++
 tb/tb_oled_spi_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_spi_arbiter_if.sv
// Bundle between the OLED byte producers, the shared SPI byte master and the arbiter.
// The master modport is the arbiter's view; slave is the requester/SPI-master side.
interface oled_spi_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_send;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_dc;
    logic [NUM_REQ-1:0]        req_done;
    logic                      init_done;
    logic                      spi_send;
    logic [DATA_W-1:0]         spi_data;
    logic                      spi_dc;
    logic                      spi_send_done;
    logic [GW-1:0]             grant_id;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        input  req_send, req_data, req_dc, init_done, spi_send_done,
        output req_done, spi_send, spi_data, spi_dc, grant_id, busy, timeout_err
    );

    modport slave (
        output req_send, req_data, req_dc, init_done, spi_send_done,
        input  req_done, spi_send, spi_data, spi_dc, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/oled_spi_arbiter.sv
// Round-robin arbiter sharing one SPI byte master among NUM_REQ OLED byte producers.
// Optional WAIT watchdog enabled by defining OLED_SPI_ARB_TIMEOUT_EN.
module oled_spi_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                reset,
    oled_spi_arbiter_if.master  bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    typedef struct packed {
        logic [GW-1:0]     id;
        logic [DATA_W-1:0] data;
        logic              dc;
    } grant_t;

    state_t                         state, state_nxt;
    logic   [GW-1:0]                rr_ptr, rr_nxt;
    grant_t                         grant_q, grant_nxt;
    logic                           send_q, send_nxt;
    logic   [NUM_REQ-1:0]           done_q, done_nxt;
    logic                           busy_q, busy_nxt;
    logic   [NUM_REQ-1:0]           eligible;
    logic   [NUM_REQ-1:0][DATA_W-1:0] req_bytes;
    logic                           win_found;
    logic   [GW-1:0]                win_idx;
    int                             scan_idx;
    logic                           wait_expired;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    // Only the init sequencer may talk to the panel until init has finished.
    assign eligible = bus.req_send & (bus.init_done ? {NUM_REQ{1'b1}} : NUM_REQ'(1));

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && eligible[GW'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = GW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        grant_nxt = grant_q;
        send_nxt  = 1'b0;
        done_nxt  = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nxt.id   = win_idx;
                    grant_nxt.data = req_bytes[win_idx];
                    grant_nxt.dc   = bus.req_dc[win_idx];
                    send_nxt       = 1'b1;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (bus.spi_send_done || wait_expired) begin
                    done_nxt[grant_q.id] = 1'b1;
                    rr_nxt    = (grant_q.id == GW'(NUM_REQ-1)) ? '0 : grant_q.id + 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            send_q  <= 1'b0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_nxt;
            grant_q <= grant_nxt;
            send_q  <= send_nxt;
            done_q  <= done_nxt;
            busy_q  <= busy_nxt;
        end
    end

`ifdef OLED_SPI_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] wait_cnt;
    logic          timeout_q;

    // A done arriving on the last allowed cycle wins over the abort.
    assign wait_expired = (state == WAIT) && !bus.spi_send_done &&
                          (wait_cnt == TW'(TIMEOUT_CYC-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (wait_expired) timeout_q <= 1'b1;
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign wait_expired    = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.spi_send = send_q;
    assign bus.spi_data = grant_q.data;
    assign bus.spi_dc   = grant_q.dc;
    assign bus.grant_id = grant_q.id;
    assign bus.req_done = done_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Scoreboard bench for oled_spi_arbiter: expected grants queued at stimulus time,
// checked when spi_send fires; req_done checked against the last grant.
module tb_oled_spi_arbiter;
    localparam int NUM_REQ     = 3;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int GW          = 2;

    typedef struct packed {
        logic [GW-1:0]     id;
        logic [DATA_W-1:0] data;
        logic              dc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    oled_spi_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    oled_spi_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int        n_chk  = 0;
    int        n_fail = 0;
    int        n_send = 0;
    int        n_done = 0;
    exp_t      exp_q[$];
    logic      pending   = 1'b0;
    logic      prev_send = 1'b0;
    logic [GW-1:0] cur_id = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pending   = 1'b0;
            prev_send = 1'b0;
        end else begin
            if (bus.spi_send) begin
                n_send++;
                chk("send_1cyc", 32'(prev_send), 0);
                chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("grant_id", 32'(bus.grant_id), 32'(e.id));
                    chk("spi_data", 32'(bus.spi_data), 32'(e.data));
                    chk("spi_dc",   32'(bus.spi_dc),   32'(e.dc));
                    cur_id = e.id;
                end
                pending = 1'b1;
            end
            if (bus.req_done != '0) begin
                n_done++;
                chk("done_onehot", 32'(bus.req_done), 32'(3'b001 << cur_id));
                chk("done_pending", 32'(pending), 1);
                pending = 1'b0;
            end
            prev_send = bus.spi_send;
        end
    end

    task automatic set_req(input int i, input logic [7:0] d, input logic dc);
        bus.req_data[i*DATA_W +: DATA_W] = d;
        bus.req_dc[i] = dc;
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic dc);
        exp_t e;
        e.id = GW'(id); e.data = d; e.dc = dc;
        exp_q.push_back(e);
    endtask

    task automatic wait_send(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.spi_send && lat < 300);
        chk("send_seen", 32'(bus.spi_send), 1);
    endtask

    task automatic finish(input int dly, input logic [NUM_REQ-1:0] drop);
        int n;
        repeat (dly) @(negedge clk);
        bus.spi_send_done = 1'b1;
        @(negedge clk);
        bus.spi_send_done = 1'b0;
        n = 1;
        while (bus.req_done == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_lat", n, 1);
        bus.req_send = bus.req_send & ~drop;
    endtask

    initial begin
        int   lat, base, n;
        logic all_busy, any_done;
        bus.req_send      = '0;
        bus.req_data      = '0;
        bus.req_dc        = '0;
        bus.init_done     = 1'b0;
        bus.spi_send_done = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_spi_send", 32'(bus.spi_send), 0);
        chk("rst_spi_data", 32'(bus.spi_data), 0);
        chk("rst_spi_dc",   32'(bus.spi_dc), 0);
        chk("rst_req_done", 32'(bus.req_done), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_busy",     32'(bus.busy), 0);
        chk("rst_timeout",  32'(bus.timeout_err), 0);
        reset = 1'b0;
        @(negedge clk);

        // Init sequencer byte before init_done
        set_req(0, 8'hAE, 1'b0);
        push(0, 8'hAE, 1'b0);
        bus.req_send = 3'b001;
        wait_send(lat);
        chk("issue_lat", lat, 1);
        finish(5, 3'b001);
        @(negedge clk);
        chk("busy_idle", 32'(bus.busy), 0);

        // Draw/command traffic gated until init_done
        set_req(1, 8'h11, 1'b1);
        set_req(2, 8'h22, 1'b0);
        bus.req_send = 3'b110;
        base = n_send;
        repeat (100) @(negedge clk);
        chk("gated_sends", n_send - base, 0);
        chk("gated_busy", 32'(bus.busy), 0);
        push(1, 8'h11, 1'b1);
        push(2, 8'h22, 1'b0);
        bus.init_done = 1'b1;
        wait_send(lat);
        finish(3, 3'b010);
        wait_send(lat);
        finish(2, 3'b100);

        // All three held: round-robin order 0,1,2,0,1
        set_req(0, 8'hA0, 1'b1);
        set_req(1, 8'hA1, 1'b0);
        set_req(2, 8'hA2, 1'b1);
        push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b0); push(2, 8'hA2, 1'b1);
        push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b0);
        bus.req_send = 3'b111;
        for (int i = 0; i < 5; i++) begin
            wait_send(lat);
            finish(1 + i, (i == 4) ? 3'b111 : 3'b000);
        end

        // Requester drops and changes data after grant
        set_req(2, 8'h3C, 1'b1);
        push(2, 8'h3C, 1'b1);
        bus.req_send = 3'b100;
        wait_send(lat);
        @(negedge clk);
        bus.req_send = 3'b000;
        set_req(2, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        chk("latched_data", 32'(bus.spi_data), 32'h3C);
        chk("latched_dc",   32'(bus.spi_dc), 1);
        finish(1, 3'b000);

        // Reset during WAIT aborts silently
        set_req(1, 8'h77, 1'b0);
        push(1, 8'h77, 1'b0);
        bus.req_send = 3'b010;
        wait_send(lat);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.req_send = 3'b000;
        @(negedge clk);
        chk("rst_mid_outs", 32'({bus.spi_send, bus.req_done, bus.busy, bus.grant_id,
                                 bus.spi_data, bus.spi_dc, bus.timeout_err}), 0);
        reset = 1'b0;
        base = n_done;
        repeat (5) @(negedge clk);
        chk("rst_no_done", n_done - base, 0);
        set_req(0, 8'h81, 1'b1);
        set_req(1, 8'h82, 1'b0);
        push(0, 8'h81, 1'b1);
        push(1, 8'h82, 1'b0);
        bus.req_send = 3'b011;
        wait_send(lat);
        finish(2, 3'b001);
        wait_send(lat);
        finish(2, 3'b010);

        // Master never answers
        chk("timeout_clear", 32'(bus.timeout_err), 0);
`ifdef OLED_SPI_ARB_TIMEOUT_EN
        set_req(0, 8'h5A, 1'b0);
        set_req(1, 8'h5B, 1'b1);
        push(0, 8'h5A, 1'b0);
        push(1, 8'h5B, 1'b1);
        bus.req_send = 3'b011;
        wait_send(lat);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_done == '0 && n < 100);
        chk("timeout_lat", n, TIMEOUT_CYC + 1);
        chk("timeout_err", 32'(bus.timeout_err), 1);
        bus.req_send = 3'b010;
        wait_send(lat);
        finish(2, 3'b010);
        chk("timeout_sticky", 32'(bus.timeout_err), 1);
`else
        set_req(0, 8'h5A, 1'b0);
        push(0, 8'h5A, 1'b0);
        bus.req_send = 3'b001;
        wait_send(lat);
        all_busy = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            all_busy = all_busy & bus.busy;
            any_done = any_done | (bus.req_done != '0);
        end
        chk("hang_busy", 32'(all_busy), 1);
        chk("hang_no_done", 32'(any_done), 0);
        chk("hang_no_timeout", 32'(bus.timeout_err), 0);
        reset = 1'b1;
        bus.req_send = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
